// File: rtl/dict_stream_if.sv
// dict_stream_if: index-input and serial-output ready/valid handshakes
// between the index source, the decompressor and the bit consumer.
interface dict_stream_if #(
    parameter int INDEX_BITS = 4
);
    logic                  idx_valid;
    logic                  idx_ready;
    logic [INDEX_BITS-1:0] idx_data;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_data;
    logic                  ser_last;

    modport master (
        output idx_valid, idx_data, ser_ready,
        input  idx_ready, ser_valid, ser_data, ser_last
    );

    modport slave (
        input  idx_valid, idx_data, ser_ready,
        output idx_ready, ser_valid, ser_data, ser_last
    );
endinterface

// File: rtl/dict_stream_decompressor.sv
// dict_stream_decompressor: FIFO-buffered codebook expansion to a bit-serial
// stream. Define DICT_DEFAULT_CB_EN to reset the codebook to the default table.
module dict_stream_decompressor #(
    parameter int  CHUNK_SIZE    = 8,
    parameter int  CODEBOOK_SIZE = 16,
    parameter int  FIFO_DEPTH    = 4,
    parameter int  LSB_FIRST     = 0,
    localparam int INDEX_BITS    = $clog2(CODEBOOK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cb_we,
    input  logic [INDEX_BITS-1:0] cb_waddr,
    input  logic [CHUNK_SIZE-1:0] cb_wdata,
    dict_stream_if.slave          s,
    output logic                  busy,
    output logic [15:0]           chunk_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CHUNK_SIZE);
`ifdef DICT_DEFAULT_CB_EN
    localparam bit DEF_EN = 1'b1;
`else
    localparam bit DEF_EN = 1'b0;
`endif
    localparam logic [127:0] DEF_TABLE =
        128'h0022_99BB_FF88_CC77_0FF0_55AA_33CC_E31C;

    function automatic logic [CHUNK_SIZE-1:0] cb_reset_val(input int i);
        logic [7:0] b;
        b = (DEF_EN && i < 16) ? DEF_TABLE[8*(15 - (i % 16)) +: 8] : 8'h00;
        return CHUNK_SIZE'(b);
    endfunction

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [CHUNK_SIZE-1:0] cb [CODEBOOK_SIZE];
    logic [INDEX_BITS-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]         wp, rp;
    logic [PW:0]           count;
    state_t                state;
    logic [CHUNK_SIZE-1:0] sreg, sreg_nx, head_val;
    logic [BW-1:0]         bcnt;
    logic                  push, pop, hs, at_last, fifo_ne, wr_ok;
    logic [INDEX_BITS-1:0] head;

    assign head    = fifo[rp];
    assign fifo_ne = (count != '0);
    assign at_last = (bcnt == BW'(CHUNK_SIZE - 1));
    assign hs      = (state == SHIFT) && s.ser_ready;
    assign push    = s.idx_valid && s.idx_ready;
    assign pop     = fifo_ne && ((state == IDLE) || (hs && at_last));
    assign sreg_nx = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);

    // Out-of-range indices only exist for non-power-of-2 codebooks.
    if (CODEBOOK_SIZE == (1 << INDEX_BITS)) begin : g_full
        assign head_val = cb[head];
        assign wr_ok    = 1'b1;
    end else begin : g_part
        assign head_val = (int'(head) < CODEBOOK_SIZE) ? cb[head] : '0;
        assign wr_ok    = (int'(cb_waddr) < CODEBOOK_SIZE);
    end

    assign s.idx_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign s.ser_valid = (state == SHIFT);
    assign s.ser_last  = (state == SHIFT) && at_last;
    assign s.ser_data  = (state == SHIFT) &&
        ((LSB_FIRST != 0) ? sreg[0] : sreg[CHUNK_SIZE-1]);
    assign busy        = fifo_ne || (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CODEBOOK_SIZE; i++)
                cb[i] <= cb_reset_val(i);
        end else if (cb_we && wr_ok) begin
            cb[cb_waddr] <= cb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wp] <= s.idx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= wp + PW'(1);
            if (pop)
                rp <= rp + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            bcnt        <= '0;
            chunk_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fifo_ne) begin
                        sreg  <= head_val;
                        bcnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (s.ser_ready) begin
                        if (at_last) begin
                            chunk_count <= chunk_count + 16'd1;
                            bcnt        <= '0;
                            if (fifo_ne) begin
                                sreg <= head_val;
                            end else begin
                                sreg  <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            sreg <= sreg_nx;
                            bcnt <= bcnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dict_stream_decompressor.sv
// tb_dict_stream_decompressor: directed table-driven bench for the
// streaming dictionary decompressor (MSB-first and LSB-first instances).
module tb_dict_stream_decompressor;
    logic        clk = 1'b0;
    logic        rst;
    logic        cb_we;
    logic [3:0]  cb_waddr;
    logic [7:0]  cb_wdata;
    logic        busy, busy_l;
    logic [15:0] cc, cc_l;
    logic        rdy_req, rnd_bp, rnd_bit;

    int n_chk = 0;
    int n_fail = 0;

    dict_stream_if #(.INDEX_BITS(4)) m ();
    dict_stream_if #(.INDEX_BITS(4)) ml ();

    dict_stream_decompressor #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .cb_we(cb_we), .cb_waddr(cb_waddr),
        .cb_wdata(cb_wdata), .s(m), .busy(busy), .chunk_count(cc)
    );

    dict_stream_decompressor #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .cb_we(cb_we), .cb_waddr(cb_waddr),
        .cb_wdata(cb_wdata), .s(ml), .busy(busy_l), .chunk_count(cc_l)
    );

    always #5 clk = ~clk;

    assign m.ser_ready  = rnd_bp ? rnd_bit : rdy_req;
    assign ml.ser_ready = 1'b1;

    initial rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    // Serial monitor for the MSB-first instance.
    logic [7:0] cur;
    int         cur_n = 0;
    logic [7:0] got_q[$];
    int         len_q[$];
    int         cyc = 0;
    int         first_hs = -1;
    int         last_hs = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            cur_n = 0;
            cur   = '0;
        end else if (m.ser_valid && m.ser_ready) begin
            cur = {cur[6:0], m.ser_data};
            cur_n++;
            if (first_hs < 0)
                first_hs = cyc;
            last_hs = cyc;
            if (m.ser_last) begin
                got_q.push_back(cur);
                len_q.push_back(cur_n);
                cur_n = 0;
            end
        end
    end

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
    } vec_t;

    vec_t       tab[16];
    logic [7:0] model[16];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clr();
        got_q.delete();
        len_q.delete();
        first_hs = -1;
        last_hs  = -1;
    endtask

    task automatic cbw(input logic [3:0] a, input logic [7:0] d);
        cb_we    = 1'b1;
        cb_waddr = a;
        cb_wdata = d;
        @(posedge clk);
        #1;
        cb_we    = 1'b0;
        model[a] = d;
    endtask

    task automatic push(input logic [3:0] idx);
        int t = 0;
        m.idx_valid = 1'b1;
        m.idx_data  = idx;
        @(negedge clk);
        while (!m.idx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: idx %0h never accepted", idx);
        end
        @(posedge clk);
        #1;
        m.idx_valid = 1'b0;
    endtask

    task automatic wait_chunks(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("chunks_arrived", got_q.size(), n);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [3:0] ri;
        logic       hold;

        tab = '{
            '{4'd0, 8'h00}, '{4'd1, 8'h22}, '{4'd2, 8'h99}, '{4'd3, 8'hBB},
            '{4'd4, 8'hFF}, '{4'd5, 8'h88}, '{4'd6, 8'hCC}, '{4'd7, 8'h77},
            '{4'd8, 8'h0F}, '{4'd9, 8'hF0}, '{4'd10, 8'h55}, '{4'd11, 8'hAA},
            '{4'd12, 8'h33}, '{4'd13, 8'hCC}, '{4'd14, 8'hE3}, '{4'd15, 8'h1C}
        };
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        rst = 1'b1;
        cb_we = 1'b0;
        cb_waddr = '0;
        cb_wdata = '0;
        rdy_req = 1'b1;
        rnd_bp = 1'b0;
        m.idx_valid = 1'b0;
        m.idx_data = '0;
        ml.idx_valid = 1'b0;
        ml.idx_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_idx_ready", m.idx_ready, 1);
        check("rst_ser_valid", m.ser_valid, 0);
        check("rst_ser_data", m.ser_data, 0);
        check("rst_ser_last", m.ser_last, 0);
        check("rst_busy", busy, 0);
        check("rst_chunk_count", cc, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency and unprogrammed (all-zero) codebook.
        clr();
        push(4'd7);
        check("lat_valid_edge_n", m.ser_valid, 0);
        check("lat_busy_edge_n", busy, 1);
        @(posedge clk);
        #1;
        check("lat_valid_edge_n1", m.ser_valid, 1);
        check("lat_data_edge_n1", m.ser_data, 0);
        wait_chunks(1, 30);
        check("unprogrammed_chunk", got_q[0], 8'h00);
        check("unprogrammed_count", cc, 1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Table: program every entry, stream indices 0..15 back to back.
        for (int i = 0; i < 16; i++) cbw(tab[i].idx, tab[i].val);
        clr();
        for (int i = 0; i < 16; i++) push(tab[i].idx);
        wait_chunks(16, 300);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tab_chunk%0d", i), got_q[i], tab[i].val);
            check($sformatf("tab_len%0d", i), len_q[i], 8);
        end
        check("tab_no_gaps", last_hs - first_hs, 127);
        check("tab_chunk_count", cc, 16);
        check("busy_fall", busy, 0);

        // LSB-first instance: A5 then F0.
        cbw(4'd3, 8'hA5);
        ml.idx_valid = 1'b1;
        ml.idx_data = 4'd3;
        @(posedge clk);
        #1;
        ml.idx_data = 4'd9;
        @(posedge clk);
        #1;
        ml.idx_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            v = (k < 8) ? 8'hA5 : 8'hF0;
            check($sformatf("lsb_bit%0d", k),
                  {ml.ser_valid, ml.ser_last, ml.ser_data},
                  {1'b1, (k % 8) == 7, v[k % 8]});
            @(posedge clk);
            #1;
        end
        check("lsb_chunk_count", cc_l, 2);

        // Backpressure: 1 in shifter + 4 in FIFO, 6th push stalls.
        clr();
        rdy_req = 1'b0;
        @(posedge clk);
        #1;
        push(4'd10);
        push(4'd1);
        push(4'd2);
        push(4'd3);
        push(4'd4);
        check("bp_full_ready", m.idx_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_valid", m.ser_valid, 1);
        v = model[10];
        hold = v[7];
        m.idx_valid = 1'b1;
        m.idx_data = 4'd5;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_stall%0d", k),
                  {m.idx_ready, m.ser_data, m.ser_last}, {1'b0, hold, 1'b0});
        end
        rdy_req = 1'b1;
        push(4'd5);
        wait_chunks(6, 200);
        check("bp_chunk0", got_q[0], model[10]);
        check("bp_chunk1", got_q[1], model[1]);
        check("bp_chunk2", got_q[2], model[2]);
        check("bp_chunk3", got_q[3], model[3]);
        check("bp_chunk4", got_q[4], model[4]);
        check("bp_chunk5", got_q[5], model[5]);
        check("bp_chunk_count", cc, 22);

        // Codebook write while index 2 is being shifted.
        clr();
        push(4'd2);
        push(4'd2);
        repeat (3) @(posedge clk);
        #1;
        cbw(4'd2, 8'hFF);
        wait_chunks(2, 100);
        check("wr_during_old", got_q[0], 8'h99);
        check("wr_during_new", got_q[1], 8'hFF);
        check("wr_chunk_count", cc, 24);

        // Reset on the 4th bit of a chunk with 3 indices queued.
        clr();
        push(4'd6);
        push(4'd7);
        push(4'd8);
        push(4'd11);
        @(posedge clk);
        #1;
        check("pre_rst_valid", m.ser_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst",
              {m.ser_valid, busy, m.idx_ready, m.ser_last},
              {1'b0, 1'b0, 1'b1, 1'b0});
        check("mid_rst_count", cc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_quiet%0d", k), m.ser_valid, 0);
        end
        clr();
        cbw(4'd4, 8'h3C);
        push(4'd4);
        wait_chunks(1, 30);
        check("post_rst_chunk", got_q[0], 8'h3C);
        check("post_rst_count", cc, 1);

        // Random backpressure, 200 random indices against the model.
        for (int i = 0; i < 16; i++) cbw(4'(i), 8'($urandom));
        clr();
        exp_q.delete();
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ri = 4'($urandom_range(0, 15));
            exp_q.push_back(model[ri]);
            push(ri);
        end
        wait_chunks(200, 6000);
        rnd_bp = 1'b0;
        for (int i = 0; i < 200 && i < got_q.size(); i++)
            check($sformatf("rnd_chunk%0d", i), got_q[i], exp_q[i]);
        check("rnd_chunk_count", cc, 201);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dict_stream_decompressor.md
# dict_stream_decompressor

Streaming successor to the fixed-codebook dictionary decompressor. It accepts a stream of codebook indices over a ready/valid handshake and buffers them in an index FIFO. It expands each index through a run-time-programmable codebook and emits the chunk bit-serially over a second ready/valid handshake, with selectable bit order. It sits between the compressed-index source and the serial unary/bit-stream consumer. Chunks go out back-to-back with no idle cycle between them.

## Interface
- CHUNK_SIZE, 8, bits per decompressed chunk (≥2)
- CODEBOOK_SIZE, 16, codebook entries (≥2); INDEX_BITS = $clog2(CODEBOOK_SIZE)
- FIFO_DEPTH, 4, index FIFO entries (power of 2, ≥2)
- LSB_FIRST, 0, 0 = serialise MSB first, 1 = LSB first
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cb_we  in  1  codebook write strobe
- cb_waddr  in  INDEX_BITS  codebook write address
- cb_wdata  in  CHUNK_SIZE  codebook write data
- idx_valid  in  1  index available
- idx_ready  out  1  FIFO can accept an index
- idx_data  in  INDEX_BITS  compressed index
- ser_valid  out  1  ser_data holds a valid bit
- ser_ready  in  1  consumer takes the bit
- ser_data  out  1  serial output bit
- ser_last  out  1  current bit is the final bit of its chunk
- busy  out  1  FIFO non-empty or shifter active
- chunk_count  out  16  chunks fully emitted; wraps modulo 2^16

## Operation
- Codebook: CODEBOOK_SIZE × CHUNK_SIZE register array.
  - Written on the clk edge when cb_we=1.
  - cb_waddr ≥ CODEBOOK_SIZE: the write is ignored.
- Index FIFO:
  - Push on idx_valid && idx_ready.
  - idx_ready = (count != FIFO_DEPTH).
  - When full, idx_ready stays 0 even if a pop occurs in the same cycle; there is no combinational ready path.
  - Simultaneous push and pop with 0 < count < FIFO_DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Shifter FSM, two states: IDLE and SHIFT.
  - IDLE: if the FIFO is non-empty, pop the head, latch codebook[head] into the shift register, clear the bit counter, and go to SHIFT.
  - SHIFT: ser_valid=1. On each ser_valid && ser_ready, shift one position and increment the bit counter.
  - SHIFT, final bit: on the handshake where the bit counter = CHUNK_SIZE-1:
    - increment chunk_count;
    - if the FIFO is non-empty, pop and load the next chunk on the same edge and stay in SHIFT;
    - otherwise go to IDLE.
  - ser_ready=0 in SHIFT: ser_data, ser_last and state hold.
- Bit order:
  - LSB_FIRST=0: ser_data = shift_reg[CHUNK_SIZE-1], with a left shift.
  - LSB_FIRST=1: ser_data = shift_reg[0], with a right shift.
- ser_last = (state==SHIFT) && (bit counter == CHUNK_SIZE-1).
- An index ≥ CODEBOOK_SIZE, which is only possible when CODEBOOK_SIZE is not a power of 2, expands to all zeros.
- Codebook writes never affect a chunk already latched. A write and a load of the same address on the same edge load the old value.

## Timing
- Reset values (rst=1):
  - state IDLE, FIFO empty, shift register 0, bit counter 0, chunk_count 0;
  - idx_ready=1, ser_valid=0, ser_data=0, ser_last=0, busy=0;
  - codebook as defined under Configuration.
- Reset mid-chunk discards the partial chunk and all FIFO contents immediately; no further bits are emitted.
- Latency: an index pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. ser_valid=1 and its first bit are visible after edge N+1 (2 cycles).
- Throughput: with ser_ready held at 1 and the FIFO kept non-empty, one bit per cycle and zero bubbles between chunks.
- busy falls the cycle after the last handshake of the final chunk when the FIFO is empty.

## Configuration
- DICT_DEFAULT_CB_EN defined: reset loads the default codebook into entries 0–15. Entries beyond 15 reset to 0, and values are truncated or zero-extended to CHUNK_SIZE. Default table, in hex:
  - 00, 22, 99, BB, FF, 88, CC, 77
  - 0F, F0, 55, AA, 33, CC, E3, 1C
- DICT_DEFAULT_CB_EN undefined: all codebook entries reset to 0 and must be programmed before use.

## Test plan
- Default codebook (macro defined), defaults, ser_ready=1, push indices 0..15 → the serial stream MSB-first matches the table. ser_last pulses every 8th bit, chunk_count=16, and there are no gaps between chunks.
- Program entry 3 = 8'hA5 with LSB_FIRST=1, push index 3 → bits 1,0,1,0,0,1,0,1, ser_last on the 8th.
- Hold ser_ready=0 and push 5 indices (FIFO_DEPTH=4) → idx_ready=0 after 4 in FIFO plus 1 in the shifter. The 6th push stalls and ser_data holds steady.
- Write cb entry 2 = 8'hFF while index 2 is being shifted (old value 8'h99) → the current chunk emits 8'h99 and the next index-2 chunk emits 8'hFF.
- Assert rst on bit 4 of a chunk with 3 indices queued → ser_valid=0, busy=0, chunk_count=0, idx_ready=1 immediately. After release, a push of index 4 yields a fresh chunk.
- Random ser_ready backpressure over 200 random indices → the reconstructed chunks equal the codebook lookups in order.
